// File: rtl/fab_reset_sequencer.sv
// fab_reset_sequencer: fabric-side reset/boot sequencer feeding the system builder.
// Holds FAB_RESET_N low until the CCC is locked and stable, waits for INIT_DONE and
// MSS_READY with a retried timeout, then releases the user-fabric reset after a delay.
module fab_reset_sequencer #(
  parameter int unsigned HOLD_CYCLES        = 64,
  parameter int unsigned LOCK_STABLE_CYCLES = 256,
  parameter int unsigned INIT_TIMEOUT       = 1000000,
  parameter int unsigned RELEASE_DELAY      = 16,
  parameter int unsigned DEBOUNCE_CYCLES    = 1024,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic       CLK_BASE,
  input  logic       RESET_N,
  input  logic       CCC_LOCK,
  input  logic       INIT_DONE,
  input  logic       MSS_READY,
  input  logic       SW_RESET_REQ_N,
  output logic       FAB_RESET_N,
  output logic       FABRIC_RESET_N,
  output logic [2:0] SEQ_STATE,
  output logic [1:0] RESET_CAUSE,
  output logic       TIMEOUT_ERR
);

  localparam int unsigned MAX_HL  = (HOLD_CYCLES > LOCK_STABLE_CYCLES) ? HOLD_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MAX_IR  = (INIT_TIMEOUT > RELEASE_DELAY) ? INIT_TIMEOUT : RELEASE_DELAY;
  localparam int unsigned MAX_CYC = (MAX_HL > MAX_IR) ? MAX_HL : MAX_IR;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned RETRY_W = 3;

  localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LOCK_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   INIT_LAST  = CNT_W'(INIT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   REL_LAST   = CNT_W'(RELEASE_DELAY - 1);
  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);

  localparam logic [1:0] CAUSE_POR       = 2'd0;
  localparam logic [1:0] CAUSE_LOCK_LOSS = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT   = 2'd2;
  localparam logic [1:0] CAUSE_BUTTON    = 2'd3;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_WAIT_INIT = 3'd2,
    ST_DELAY     = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [RETRY_W-1:0] retry;
  logic [RETRY_W-1:0] retry_inc;
  logic               btn_meta;
  logic               btn_sync;
  logic               btn_db;
  logic [DB_W-1:0]    db_cnt;
  logic               press;
  logic               lock_lost;

  assign SEQ_STATE = state;
  assign retry_inc = retry + RETRY_W'(1);
  assign lock_lost = !CCC_LOCK &&
                     ((state == ST_WAIT_INIT) || (state == ST_DELAY) || (state == ST_RUN));

  // Two-flop synchronizer for the asynchronous push button.
  always_ff @(posedge CLK_BASE) begin
    if (!RESET_N) begin
      btn_meta <= 1'b1;
      btn_sync <= 1'b1;
    end else begin
      btn_meta <= SW_RESET_REQ_N;
      btn_sync <= btn_meta;
    end
  end

  // Debounce: debounced level follows only after DEBOUNCE_CYCLES equal differing samples; press pulses on 1->0.
  always_ff @(posedge CLK_BASE) begin
    if (!RESET_N) begin
      db_cnt <= '0;
      btn_db <= 1'b1;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (btn_sync == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt <= '0;
        btn_db <= btn_sync;
        press  <= btn_db;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // Sequencer FSM; the two reset outputs follow the state held during the previous cycle.
  always_ff @(posedge CLK_BASE) begin
    if (!RESET_N) begin
      state          <= ST_HOLD;
      cnt            <= '0;
      retry          <= '0;
      RESET_CAUSE    <= CAUSE_POR;
      TIMEOUT_ERR    <= 1'b0;
      FAB_RESET_N    <= 1'b0;
      FABRIC_RESET_N <= 1'b0;
    end else begin
      FAB_RESET_N    <= (state == ST_WAIT_INIT) || (state == ST_DELAY) || (state == ST_RUN);
      FABRIC_RESET_N <= (state == ST_RUN);
      if (lock_lost) begin
        state       <= ST_HOLD;
        cnt         <= '0;
        RESET_CAUSE <= CAUSE_LOCK_LOSS;
      end else if (press && (state != ST_HOLD)) begin
        state       <= ST_HOLD;
        cnt         <= '0;
        RESET_CAUSE <= CAUSE_BUTTON;
        TIMEOUT_ERR <= 1'b0;
        if (state == ST_FAULT) begin
          retry <= '0;
        end
      end else begin
        case (state)
          ST_HOLD: begin
            // Count saturates at the last hold cycle while the button stays pressed.
            if (cnt != HOLD_LAST) begin
              cnt <= cnt + CNT_W'(1);
            end else if (btn_db) begin
              state <= ST_WAIT_LOCK;
              cnt   <= '0;
            end
          end
          ST_WAIT_LOCK: begin
            if (!CCC_LOCK) begin
              cnt <= '0;
            end else if (cnt == LOCK_LAST) begin
              state <= ST_WAIT_INIT;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_WAIT_INIT: begin
            // Init completion wins over a timeout expiring in the same cycle.
            if (INIT_DONE && MSS_READY) begin
              state <= ST_DELAY;
              cnt   <= '0;
            end else if (cnt == INIT_LAST) begin
              retry <= retry_inc;
              cnt   <= '0;
              if (retry_inc == RETRY_MAX) begin
                state       <= ST_FAULT;
                TIMEOUT_ERR <= 1'b1;
              end else begin
                state       <= ST_HOLD;
                RESET_CAUSE <= CAUSE_TIMEOUT;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_DELAY: begin
            if (cnt == REL_LAST) begin
              state <= ST_RUN;
              cnt   <= '0;
              retry <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_RUN: begin
            cnt <= '0;
          end
          ST_FAULT: begin
            cnt <= '0;
          end
          default: begin
            state <= ST_HOLD;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fab_reset_sequencer.sv
// Scoreboard bench for fab_reset_sequencer: stimulus queues the expected output
// tuple and cycle of every output change; the monitor pops one entry per change.
module tb_fab_reset_sequencer;

  localparam int unsigned HOLD_CYCLES        = 4;
  localparam int unsigned LOCK_STABLE_CYCLES = 8;
  localparam int unsigned INIT_TIMEOUT       = 50;
  localparam int unsigned RELEASE_DELAY      = 3;
  localparam int unsigned DEBOUNCE_CYCLES    = 5;
  localparam int unsigned MAX_RETRIES        = 2;

  logic       clk = 1'b0;
  logic       RESET_N;
  logic       CCC_LOCK;
  logic       INIT_DONE;
  logic       MSS_READY;
  logic       SW_RESET_REQ_N;
  logic       FAB_RESET_N;
  logic       FABRIC_RESET_N;
  logic [2:0] SEQ_STATE;
  logic [1:0] RESET_CAUSE;
  logic       TIMEOUT_ERR;

  typedef struct {
    int         at;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   tests  = 0;
  int   failed = 0;
  bit   done   = 1'b0;

  fab_reset_sequencer #(
    .HOLD_CYCLES       (HOLD_CYCLES),
    .LOCK_STABLE_CYCLES(LOCK_STABLE_CYCLES),
    .INIT_TIMEOUT      (INIT_TIMEOUT),
    .RELEASE_DELAY     (RELEASE_DELAY),
    .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
    .MAX_RETRIES       (MAX_RETRIES)
  ) dut (
    .CLK_BASE      (clk),
    .RESET_N       (RESET_N),
    .CCC_LOCK      (CCC_LOCK),
    .INIT_DONE     (INIT_DONE),
    .MSS_READY     (MSS_READY),
    .SW_RESET_REQ_N(SW_RESET_REQ_N),
    .FAB_RESET_N   (FAB_RESET_N),
    .FABRIC_RESET_N(FABRIC_RESET_N),
    .SEQ_STATE     (SEQ_STATE),
    .RESET_CAUSE   (RESET_CAUSE),
    .TIMEOUT_ERR   (TIMEOUT_ERR)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge N the value read at the following negedge is N.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input int at, input logic fab, input logic fabric, input int st,
                          input int cause, input logic err, input string name);
    exp_t e;
    e.at   = at;
    e.val  = {fab, fabric, 3'(st), 2'(cause), err};
    e.name = name;
    q.push_back(e);
  endtask

  task automatic at_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic set_init(input logic v);
    INIT_DONE = v;
    MSS_READY = v;
  endtask

  // Stimulus: directed timeline, expected changes computed by hand from the cycle of each action.
  initial begin : stim
    RESET_N = 1'b0; CCC_LOCK = 1'b1; SW_RESET_REQ_N = 1'b1;
    set_init(1'b0);
    // Reset state and nominal boot (last reset edge is 3).
    push_exp(3,  0, 0, 0, 0, 0, "reset_state");
    push_exp(7,  0, 0, 1, 0, 0, "boot_wait_lock");
    push_exp(15, 0, 0, 2, 0, 0, "boot_wait_init");
    push_exp(16, 1, 0, 2, 0, 0, "boot_fab_rise_13");
    at_cyc(3);  RESET_N = 1'b1;
    at_cyc(26); set_init(1'b1);
    push_exp(27, 1, 0, 3, 0, 0, "boot_delay");
    push_exp(30, 1, 0, 4, 0, 0, "boot_run");
    push_exp(31, 1, 1, 4, 0, 0, "boot_fabric_rise");
    at_cyc(35); set_init(1'b0);
    // 3-cycle button glitch in RUN: no change expected.
    at_cyc(40); SW_RESET_REQ_N = 1'b0;
    at_cyc(43); SW_RESET_REQ_N = 1'b1;
    // Lock loss in RUN, then a one-cycle lock glitch after 6 stable WAIT_LOCK cycles.
    at_cyc(50); CCC_LOCK = 1'b0;
    push_exp(51, 1, 1, 0, 1, 0, "lockloss_hold");
    push_exp(52, 0, 0, 0, 1, 0, "lockloss_resets_low");
    push_exp(55, 0, 0, 1, 1, 0, "lockloss_wait_lock");
    at_cyc(51); CCC_LOCK = 1'b1;
    at_cyc(61); CCC_LOCK = 1'b0;
    push_exp(70, 0, 0, 2, 1, 0, "glitch_wait_init");
    push_exp(71, 1, 0, 2, 1, 0, "glitch_fab_rise");
    at_cyc(62); CCC_LOCK = 1'b1;
    at_cyc(75); set_init(1'b1);
    push_exp(76, 1, 0, 3, 1, 0, "rerun_delay");
    push_exp(79, 1, 0, 4, 1, 0, "rerun_run");
    push_exp(80, 1, 1, 4, 1, 0, "rerun_fabric_rise");
    at_cyc(82); set_init(1'b0);
    // Priority: lock drop coincides with the debounced press in RUN.
    at_cyc(90); SW_RESET_REQ_N = 1'b0;
    at_cyc(97); CCC_LOCK = 1'b0;
    push_exp(98, 1, 1, 0, 1, 0, "prio_lockloss_cause");
    push_exp(99, 0, 0, 0, 1, 0, "prio_resets_low");
    at_cyc(98);  CCC_LOCK = 1'b1;
    at_cyc(100); SW_RESET_REQ_N = 1'b1;
    // Hold waits for debounced release; then INIT never arrives: two timeouts -> FAULT.
    push_exp(108, 0, 0, 1, 1, 0, "prio_release_wait_lock");
    push_exp(116, 0, 0, 2, 1, 0, "to1_wait_init");
    push_exp(117, 1, 0, 2, 1, 0, "to1_fab_rise");
    push_exp(166, 1, 0, 0, 2, 0, "to1_timeout_hold");
    push_exp(167, 0, 0, 0, 2, 0, "to1_resets_low");
    push_exp(170, 0, 0, 1, 2, 0, "to2_wait_lock");
    push_exp(178, 0, 0, 2, 2, 0, "to2_wait_init");
    push_exp(179, 1, 0, 2, 2, 0, "to2_fab_rise");
    push_exp(228, 1, 0, 5, 2, 1, "to2_fault");
    push_exp(229, 0, 0, 5, 2, 1, "fault_resets_low");
    // 10-cycle press leaves FAULT.
    at_cyc(240); SW_RESET_REQ_N = 1'b0;
    push_exp(248, 0, 0, 0, 3, 0, "fault_button_hold");
    at_cyc(250); SW_RESET_REQ_N = 1'b1;
    push_exp(258, 0, 0, 1, 3, 0, "button_wait_lock");
    push_exp(266, 0, 0, 2, 3, 0, "button_wait_init");
    push_exp(267, 1, 0, 2, 3, 0, "button_fab_rise");
    at_cyc(270); set_init(1'b1);
    push_exp(271, 1, 0, 3, 3, 0, "button_delay");
    push_exp(274, 1, 0, 4, 3, 0, "button_run");
    push_exp(275, 1, 1, 4, 3, 0, "button_fabric_rise");
    // 20-cycle press in RUN: exactly one restart, HOLD until released.
    at_cyc(280); SW_RESET_REQ_N = 1'b0;
    push_exp(288, 1, 1, 0, 3, 0, "press20_hold");
    push_exp(289, 0, 0, 0, 3, 0, "press20_resets_low");
    at_cyc(300); SW_RESET_REQ_N = 1'b1;
    push_exp(308, 0, 0, 1, 3, 0, "press20_wait_lock");
    push_exp(316, 0, 0, 2, 3, 0, "press20_wait_init");
    push_exp(317, 1, 0, 3, 3, 0, "press20_delay");
    push_exp(320, 1, 0, 4, 3, 0, "press20_run");
    push_exp(321, 1, 1, 4, 3, 0, "press20_fabric_rise");
    // RESET_N asserted while in DELAY.
    at_cyc(330); CCC_LOCK = 1'b0;
    push_exp(331, 1, 1, 0, 1, 0, "pre_rst_hold");
    push_exp(332, 0, 0, 0, 1, 0, "pre_rst_resets_low");
    push_exp(335, 0, 0, 1, 1, 0, "pre_rst_wait_lock");
    push_exp(343, 0, 0, 2, 1, 0, "pre_rst_wait_init");
    push_exp(344, 1, 0, 3, 1, 0, "pre_rst_delay");
    at_cyc(331); CCC_LOCK = 1'b1;
    at_cyc(344); RESET_N = 1'b0;
    push_exp(345, 0, 0, 0, 0, 0, "rst_in_delay_values");
    at_cyc(347); RESET_N = 1'b1;
    push_exp(351, 0, 0, 1, 0, 0, "post_rst_wait_lock");
    push_exp(359, 0, 0, 2, 0, 0, "post_rst_wait_init");
    push_exp(360, 1, 0, 3, 0, 0, "post_rst_delay");
    push_exp(363, 1, 0, 4, 0, 0, "post_rst_run");
    push_exp(364, 1, 1, 4, 0, 0, "post_rst_fabric_rise");
    at_cyc(370); set_init(1'b0);
    // One timeout, success (clears retries), then one more timeout must not fault.
    at_cyc(380); CCC_LOCK = 1'b0;
    push_exp(381, 1, 1, 0, 1, 0, "rc_hold");
    push_exp(382, 0, 0, 0, 1, 0, "rc_resets_low");
    push_exp(385, 0, 0, 1, 1, 0, "rc_wait_lock");
    push_exp(393, 0, 0, 2, 1, 0, "rc_wait_init");
    push_exp(394, 1, 0, 2, 1, 0, "rc_fab_rise");
    push_exp(443, 1, 0, 0, 2, 0, "rc_timeout_hold");
    push_exp(444, 0, 0, 0, 2, 0, "rc_timeout_resets_low");
    push_exp(447, 0, 0, 1, 2, 0, "rc_wait_lock2");
    push_exp(455, 0, 0, 2, 2, 0, "rc_wait_init2");
    push_exp(456, 1, 0, 2, 2, 0, "rc_fab_rise2");
    at_cyc(381); CCC_LOCK = 1'b1;
    at_cyc(460); set_init(1'b1);
    push_exp(461, 1, 0, 3, 2, 0, "rc_delay");
    push_exp(464, 1, 0, 4, 2, 0, "rc_run");
    push_exp(465, 1, 1, 4, 2, 0, "rc_fabric_rise");
    at_cyc(470); set_init(1'b0);
    at_cyc(480); CCC_LOCK = 1'b0;
    push_exp(481, 1, 1, 0, 1, 0, "rc2_hold");
    push_exp(482, 0, 0, 0, 1, 0, "rc2_resets_low");
    push_exp(485, 0, 0, 1, 1, 0, "rc2_wait_lock");
    push_exp(493, 0, 0, 2, 1, 0, "rc2_wait_init");
    push_exp(494, 1, 0, 2, 1, 0, "rc2_fab_rise");
    push_exp(543, 1, 0, 0, 2, 0, "rc2_timeout_not_fault");
    push_exp(544, 0, 0, 0, 2, 0, "rc2_resets_low2");
    push_exp(547, 0, 0, 1, 2, 0, "rc2_wait_lock2");
    push_exp(555, 0, 0, 2, 2, 0, "rc2_wait_init2");
    push_exp(556, 1, 0, 2, 2, 0, "rc2_fab_rise2");
    at_cyc(481); CCC_LOCK = 1'b1;
    // INIT arrives on the very cycle the timer expires (retry would reach the maximum).
    at_cyc(604); set_init(1'b1);
    push_exp(605, 1, 0, 3, 2, 0, "init_at_timeout_success");
    push_exp(608, 1, 0, 4, 2, 0, "init_at_timeout_run");
    push_exp(609, 1, 1, 4, 2, 0, "init_at_timeout_fabric");
    at_cyc(620);
    done = 1'b1;
  end

  // Monitor: on every output change (and the first sample) pop one expectation and compare.
  initial begin : monitor
    logic [7:0] cur;
    logic [7:0] prev;
    bit         first;
    exp_t       e;
    first = 1'b1;
    prev  = '0;
    forever begin
      @(negedge clk);
      if (cyc >= 3) begin
        cur = {FAB_RESET_N, FABRIC_RESET_N, SEQ_STATE, RESET_CAUSE, TIMEOUT_ERR};
        if (first || (cur !== prev)) begin
          tests++;
          if (q.size() == 0) begin
            failed++;
            $display("FAIL unexpected_change: cycle %0d fab=%b fabric=%b seq=%0d cause=%0d err=%b, none required",
                     cyc, cur[7], cur[6], cur[5:3], cur[2:1], cur[0]);
          end else begin
            e = q.pop_front();
            if ((cur !== e.val) || (cyc != e.at)) begin
              failed++;
              $display("FAIL %s: got cycle %0d fab=%b fabric=%b seq=%0d cause=%0d err=%b, required cycle %0d fab=%b fabric=%b seq=%0d cause=%0d err=%b",
                       e.name, cyc, cur[7], cur[6], cur[5:3], cur[2:1], cur[0],
                       e.at, e.val[7], e.val[6], e.val[5:3], e.val[2:1], e.val[0]);
            end
          end
        end
        prev  = cur;
        first = 1'b0;
      end
      if (done) break;
    end
    while (q.size() != 0) begin
      e = q.pop_front();
      tests++;
      failed++;
      $display("FAIL %s: change never observed, required at cycle %0d", e.name, e.at);
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fab_reset_sequencer.md
Name: fab_reset_sequencer

Overview:
- Fabric-side reset/boot sequencer placed directly upstream of the system-builder block; its FAB_RESET_N output drives the system builder's FAB_RESET_N input.
- Holds the MSS/fabric in reset until the fabric CCC is locked and stable, then waits for INIT_DONE and MSS_READY with a timeout.
- Releases the user-fabric reset only after a further delay; restarts on CCC lock loss or a debounced push-button request.

Parameters:
HOLD_CYCLES, 64, minimum cycles FAB_RESET_N is held low on every entry to HOLD
LOCK_STABLE_CYCLES, 256, consecutive cycles CCC_LOCK must be high before releasing FAB_RESET_N
INIT_TIMEOUT, 1000000, max cycles in WAIT_INIT for INIT_DONE&MSS_READY
RELEASE_DELAY, 16, cycles between init complete and FABRIC_RESET_N release
DEBOUNCE_CYCLES, 1024, cycles the synchronized button must be stable before its debounced value changes
MAX_RETRIES, 3, consecutive init timeouts before FAULT (1..7)

Ports:
CLK_BASE  input  1  fabric CCC GL0 clock
RESET_N  input  1  synchronous active-low reset (POR-derived, already synchronized)
CCC_LOCK  input  1  fabric CCC lock
INIT_DONE  input  1  from system builder
MSS_READY  input  1  from system builder
SW_RESET_REQ_N  input  1  asynchronous push button, active-low
FAB_RESET_N  output  1  to system builder FAB_RESET_N
FABRIC_RESET_N  output  1  user-fabric reset, active-low
SEQ_STATE  output  3  current state encoding
RESET_CAUSE  output  2  0 POR, 1 LOCK_LOSS, 2 TIMEOUT, 3 BUTTON
TIMEOUT_ERR  output  1  sticky fault flag

Behaviour:
- One clock (CLK_BASE); reset is synchronous and active-low (RESET_N). All outputs registered.
- Reset values: FAB_RESET_N=0, FABRIC_RESET_N=0, SEQ_STATE=0 (HOLD), RESET_CAUSE=0, TIMEOUT_ERR=0; retry count 0; debounced button = 1 (released).
- Button path:
  - Two-flop synchronizer feeds the debounce counter. The debounced value changes only after DEBOUNCE_CYCLES consecutive equal samples that differ from it.
  - A press event is a single-cycle pulse when the debounced value goes 1->0.
- States: HOLD=0, WAIT_LOCK=1, WAIT_INIT=2, DELAY=3, RUN=4, FAULT=5.
- HOLD:
  - FAB_RESET_N=0, FABRIC_RESET_N=0.
  - Counts HOLD_CYCLES, then -> WAIT_LOCK only if the debounced button is released; otherwise stays in HOLD.
- WAIT_LOCK:
  - FAB_RESET_N=0.
  - Lock counter increments while CCC_LOCK=1 and clears to 0 when CCC_LOCK=0.
  - Counter reaching LOCK_STABLE_CYCLES -> WAIT_INIT.
- WAIT_INIT:
  - FAB_RESET_N=1; timer increments each cycle.
  - INIT_DONE=1 and MSS_READY=1 in the same cycle -> DELAY.
  - Timer reaching INIT_TIMEOUT increments retry count:
    - If the new count equals MAX_RETRIES -> FAULT.
    - Otherwise -> HOLD with cause TIMEOUT.
- DELAY: FAB_RESET_N=1; counts RELEASE_DELAY cycles -> RUN. FABRIC_RESET_N goes 1 in the first RUN cycle. Retry count clears on entry to RUN.
- RUN: FAB_RESET_N=1, FABRIC_RESET_N=1.
- FAULT:
  - FAB_RESET_N=0, FABRIC_RESET_N=0, TIMEOUT_ERR=1.
  - Exits only on a press event (-> HOLD, cause BUTTON, retry count and TIMEOUT_ERR cleared) or RESET_N.
- Restart events:
  - CCC_LOCK=0 in WAIT_INIT, DELAY or RUN -> HOLD with cause LOCK_LOSS.
  - A press event in any state except HOLD -> HOLD with cause BUTTON.
- Both resets drop to 0 in the cycle after HOLD is entered (registered outputs).
- Simultaneous-event priority: RESET_N > lock loss > press event > init timeout > normal progress. INIT_DONE&MSS_READY arriving in the same cycle as timeout expiry counts as success.
- RESET_CAUSE updates only on entry to HOLD and holds otherwise.
- Every state entry clears the shared cycle counter. Counter width is clog2 of the largest cycle parameter plus 1; no wrap-around is possible.
- Mid-sequence RESET_N low: all outputs return to reset values on the next edge, regardless of state.

Test Plan:
(Bench parameters: HOLD_CYCLES=4, LOCK_STABLE_CYCLES=8, INIT_TIMEOUT=50, RELEASE_DELAY=3, DEBOUNCE_CYCLES=5, MAX_RETRIES=2.)
- Nominal boot:
  - Stimulus: release RESET_N, CCC_LOCK=1 constant; INIT_DONE=MSS_READY=1 raised 10 cycles after FAB_RESET_N rises.
  - Response: FAB_RESET_N rises 13 cycles after reset release (4 HOLD + 8 WAIT_LOCK + 1 register); FABRIC_RESET_N rises 4 cycles after INIT_DONE&MSS_READY; SEQ_STATE=4; RESET_CAUSE=0.
- Lock glitch: CCC_LOCK drops for 1 cycle after 6 stable cycles in WAIT_LOCK -> lock counter restarts; FAB_RESET_N rises only after 8 further stable cycles.
- Lock loss in RUN: CCC_LOCK=0 for 1 cycle -> FAB_RESET_N and FABRIC_RESET_N both 0 the next cycle, RESET_CAUSE=1, full sequence re-runs.
- Timeout/fault:
  - Stimulus: INIT_DONE held 0.
  - Response: first 50-cycle timeout -> HOLD with RESET_CAUSE=2; second timeout -> SEQ_STATE=5, TIMEOUT_ERR=1, both resets 0.
  - Then a 10-cycle button press -> HOLD, RESET_CAUSE=3, TIMEOUT_ERR=0.
- Debounce: 3-cycle low glitch on SW_RESET_REQ_N in RUN -> no state change. A 20-cycle press -> exactly one restart; HOLD is held until the button is released and debounced.
- Priority: CCC_LOCK drop and debounced press in the same RUN cycle -> RESET_CAUSE=1. RESET_N asserted in DELAY -> all outputs at reset values on the next edge.
